// File: rtl/dcm_pkg.sv
// Shared types and defaults for the DCM mode scheduler.
package dcm_pkg;

  localparam int MODE_W             = 3;
  localparam int SETTLE_CYCLES_DEF  = 16;
  localparam int TIMEOUT_CYCLES_DEF = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ISSUE  = 3'd1,
    WAIT   = 3'd2,
    SETTLE = 3'd3,
    DONE   = 3'd4
  } sched_state_t;

  // One counter width serves both the echo wait and the settle window.
  function automatic int cnt_width(input int settle, input int timeout);
    int max_c;
    max_c = (settle > timeout) ? settle : timeout;
    return $clog2(max_c + 1);
  endfunction

endpackage

// File: rtl/dcm_mode_sched_arb.sv
// Two-way round-robin arbiter; the last-grant register moves only on advance.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  // last_r = 1 means B won the most recent contested grant
  logic last_r;

  // grant selection: a lone requester wins, a tie goes to the one not granted last
  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last_r ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

  // last-grant register, reset to B so A wins the first tie
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_r <= 1'b1;
    end else if (advance) begin
      last_r <= gnt[1];
    end
  end

endmodule

// File: rtl/dcm_mode_sched.sv
// Shares the DCM programming port between two requesters: issue, confirm the
// echo, settle, then acknowledge.
module dcm_mode_sched #(
  parameter int MODE_W         = dcm_pkg::MODE_W,
  parameter int SETTLE_CYCLES  = dcm_pkg::SETTLE_CYCLES_DEF,
  parameter int TIMEOUT_CYCLES = dcm_pkg::TIMEOUT_CYCLES_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_a,
  input  logic [MODE_W-1:0] mode_a,
  output logic              ack_a,
  input  logic              req_b,
  input  logic [MODE_W-1:0] mode_b,
  output logic              ack_b,
  output logic              err,
  output logic              busy,
  output logic [MODE_W-1:0] cur_mode,
  output logic [MODE_W-1:0] dcm_prog_in,
  output logic              dcm_update,
  input  logic [MODE_W-1:0] dcm_prog_out
);
  import dcm_pkg::*;

  localparam int CNT_W = cnt_width(SETTLE_CYCLES, TIMEOUT_CYCLES);

  sched_state_t      state_r, state_s;
  logic [MODE_W-1:0] mode_q_r, cur_mode_r, prog_in_r, sel_mode_s;
  logic [CNT_W-1:0]  wcnt_r, scnt_r;
  logic              gid_r, same_r;
  logic              ack_a_r, ack_b_r, err_r, busy_r, update_r;
  logic [1:0]        arb_req_s, gnt_s;
  logic              grant_s, advance_s, echo_ok_s, wait_end_s, settle_end_s;
  logic              timeout_s, ack_s;

  // The ack cycle itself must not re-grant, which matters after a timeout ack.
  assign arb_req_s    = (state_r == IDLE && !ack_a_r && !ack_b_r) ? {req_b, req_a} : 2'b00;
  assign grant_s      = |gnt_s;
  assign advance_s    = grant_s & (&arb_req_s);
  assign sel_mode_s   = gnt_s[1] ? mode_b : mode_a;
  assign echo_ok_s    = (dcm_prog_out == mode_q_r);
  assign wait_end_s   = (wcnt_r == CNT_W'(TIMEOUT_CYCLES - 1));
  assign settle_end_s = (scnt_r == CNT_W'(SETTLE_CYCLES - 1));
  assign timeout_s    = (state_r == WAIT) && !echo_ok_s && wait_end_s;
  assign ack_s        = (state_s == DONE) || timeout_s;

  rr_arb2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (arb_req_s),
    .advance (advance_s),
    .gnt     (gnt_s)
  );

  // next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (grant_s) state_s = ISSUE;
        else         state_s = IDLE;
      end
      // a same-mode request passes through ISSUE without pulsing update
      ISSUE: begin
        if (same_r) state_s = DONE;
        else        state_s = WAIT;
      end
      WAIT: begin
        if (echo_ok_s)       state_s = SETTLE;
        else if (wait_end_s) state_s = IDLE;
        else                 state_s = WAIT;
      end
      SETTLE: begin
        if (settle_end_s) state_s = DONE;
        else              state_s = SETTLE;
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // state, grant capture and confirmed mode
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= IDLE;
      mode_q_r   <= '0;
      gid_r      <= 1'b0;
      same_r     <= 1'b0;
      cur_mode_r <= '0;
    end else begin
      state_r <= state_s;
      if (grant_s) begin
        mode_q_r <= sel_mode_s;
        gid_r    <= gnt_s[1];
        same_r   <= (sel_mode_s == cur_mode_r);
      end
      if (state_r == WAIT && echo_ok_s) begin
        cur_mode_r <= mode_q_r;
      end
    end
  end

  // echo-wait and settle counters, cleared on entry to their state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wcnt_r <= '0;
      scnt_r <= '0;
    end else begin
      if (state_r == ISSUE) begin
        wcnt_r <= '0;
      end else if (state_r == WAIT && state_s == WAIT) begin
        wcnt_r <= wcnt_r + CNT_W'(1);
      end
      if (state_r == WAIT && echo_ok_s) begin
        scnt_r <= '0;
      end else if (state_r == SETTLE && !settle_end_s) begin
        scnt_r <= scnt_r + CNT_W'(1);
      end
    end
  end

  // registered outputs, computed from the upcoming state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ack_a_r   <= 1'b0;
      ack_b_r   <= 1'b0;
      err_r     <= 1'b0;
      busy_r    <= 1'b0;
      update_r  <= 1'b0;
      prog_in_r <= '0;
    end else begin
      ack_a_r  <= ack_s && !gid_r;
      ack_b_r  <= ack_s && gid_r;
      err_r    <= timeout_s;
      busy_r   <= (state_s != IDLE);
      update_r <= grant_s && (sel_mode_s != cur_mode_r);
      if (grant_s) begin
        prog_in_r <= sel_mode_s;
      end
    end
  end

  assign ack_a       = ack_a_r;
  assign ack_b       = ack_b_r;
  assign err         = err_r;
  assign busy        = busy_r;
  assign cur_mode    = cur_mode_r;
  assign dcm_prog_in = prog_in_r;
  assign dcm_update  = update_r;

endmodule

// File: tb/tb_dcm_mode_sched.sv
// Bench for dcm_mode_sched: vector table for single requests, hand sequences
// for ties, reset during settle and req dropping mid-operation.
module tb_dcm_mode_sched;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       req_a = 1'b0, req_b = 1'b0;
  logic [2:0] mode_a = 3'd0, mode_b = 3'd0;
  logic       ack_a, ack_b, err, busy, dcm_update;
  logic [2:0] cur_mode, dcm_prog_in;
  logic [2:0] dcm_prog_out = 3'd0;
  logic       echo_en = 1'b1;

  int         errors = 0, checks = 0, cyc = 0, ack_cnt = 0, upd_cnt = 0;
  logic [2:0] last_upd = 3'd0;

  typedef struct {
    logic       id;
    logic       err;
    logic [2:0] mode;
    int         cyc;
  } exp_t;

  typedef struct {
    logic       id;
    logic [2:0] mode;
    logic       echo;
    int         lat;
    logic       err;
    logic [2:0] cur;
    int         upd;
    int         busy_n;
  } vec_t;

  exp_t sb[$];
  exp_t mon_e;
  vec_t vecs[6];

  dcm_mode_sched dut (
    .clk          (clk),
    .rst          (rst),
    .req_a        (req_a),
    .mode_a       (mode_a),
    .ack_a        (ack_a),
    .req_b        (req_b),
    .mode_b       (mode_b),
    .ack_b        (ack_b),
    .err          (err),
    .busy         (busy),
    .cur_mode     (cur_mode),
    .dcm_prog_in  (dcm_prog_in),
    .dcm_update   (dcm_update),
    .dcm_prog_out (dcm_prog_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // DCM model: latches prog_in on update and echoes it, unless echo is disabled
  always @(posedge clk) begin
    if (dcm_update && echo_en) dcm_prog_out <= dcm_prog_in;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  // monitor: pops the scoreboard on every ack
  always @(negedge clk) begin
    if (rst) begin
      check("err_without_ack", 32'(err & ~(ack_a | ack_b)), 32'd0);
      check("ack_a_and_b", 32'(ack_a & ack_b), 32'd0);
      if (dcm_update) begin
        upd_cnt++;
        last_upd = dcm_prog_in;
      end
      if (ack_a | ack_b) begin
        ack_cnt++;
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_ack: ack_a=%0d ack_b=%0d, required no ack", ack_a, ack_b);
        end else begin
          mon_e = sb.pop_front();
          check("ack_id", 32'(ack_b), 32'(mon_e.id));
          check("ack_err", 32'(err), 32'(mon_e.err));
          check("ack_cur_mode", 32'(cur_mode), 32'(mon_e.mode));
          check("ack_cycle", 32'(cyc), 32'(mon_e.cyc));
        end
      end
    end
  end

  task automatic run_vec(input vec_t v, input string tag);
    int   b_n  = 0;
    int   ack0 = ack_cnt;
    int   upd0 = upd_cnt;
    bit   seen = 1'b0;
    exp_t e;
    echo_en = v.echo;
    if (v.id) begin mode_b = v.mode; req_b = 1'b1; end
    else      begin mode_a = v.mode; req_a = 1'b1; end
    e.id = v.id; e.err = v.err; e.mode = v.cur; e.cyc = cyc + 1 + v.lat;
    sb.push_back(e);
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk); #1;
      if (busy) b_n++;
      if (ack_cnt != ack0) begin
        seen  = 1'b1;
        req_a = 1'b0;
        req_b = 1'b0;
      end
    end
    check({tag, "_ack_seen"}, 32'(seen), 32'd1);
    repeat (4) begin
      @(negedge clk); #1;
      if (busy) b_n++;
    end
    check({tag, "_busy_cycles"}, 32'(b_n), 32'(v.busy_n));
    check({tag, "_updates"}, 32'(upd_cnt - upd0), 32'(v.upd));
    check({tag, "_ack_count"}, 32'(ack_cnt - ack0), 32'd1);
    if (v.upd != 0) check({tag, "_prog_in"}, 32'(last_upd), 32'(v.mode));
  endtask

  task automatic run_tie(input logic [2:0] ma, input logic [2:0] mb, input logic first_b, input string tag);
    int   ack0 = ack_cnt;
    int   upd0 = upd_cnt;
    exp_t e1, e2;
    echo_en = 1'b1;
    mode_a = ma; mode_b = mb;
    req_a = 1'b1; req_b = 1'b1;
    e1.id = first_b;  e1.err = 1'b0; e1.mode = first_b ? mb : ma; e1.cyc = cyc + 19;
    e2.id = !first_b; e2.err = 1'b0; e2.mode = first_b ? ma : mb; e2.cyc = cyc + 39;
    sb.push_back(e1);
    sb.push_back(e2);
    for (int i = 0; i < 100 && ack_cnt != ack0 + 2; i++) begin
      @(negedge clk); #1;
      if (ack_a) req_a = 1'b0;
      if (ack_b) req_b = 1'b0;
    end
    req_a = 1'b0; req_b = 1'b0;
    check({tag, "_acks"}, 32'(ack_cnt - ack0), 32'd2);
    repeat (3) @(negedge clk);
    #1;
    check({tag, "_updates"}, 32'(upd_cnt - upd0), 32'd2);
    check({tag, "_idle_after"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int ack0;
    exp_t e;
    bit seen;
    //           id    mode  echo  lat err   cur   upd busy
    vecs[0] = '{1'b0, 3'd3, 1'b1, 18, 1'b0, 3'd3, 1, 19};
    vecs[1] = '{1'b1, 3'd3, 1'b1, 1,  1'b0, 3'd3, 0, 2};
    vecs[2] = '{1'b0, 3'd6, 1'b0, 9,  1'b1, 3'd3, 1, 9};
    vecs[3] = '{1'b1, 3'd5, 1'b1, 18, 1'b0, 3'd5, 1, 19};
    vecs[4] = '{1'b0, 3'd0, 1'b1, 18, 1'b0, 3'd0, 1, 19};
    vecs[5] = '{1'b0, 3'd0, 1'b1, 1,  1'b0, 3'd0, 0, 2};

    rst = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("reset_outputs", 32'({ack_a, ack_b, err, busy, dcm_update, cur_mode, dcm_prog_in}), 32'd0);
    rst = 1'b1;
    @(negedge clk); #1;

    for (int i = 0; i < 6; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    run_tie(3'd5, 3'd2, 1'b0, "tie1");
    run_tie(3'd1, 3'd4, 1'b1, "tie2");

    // reset asserted while settling
    mode_a = 3'd6; req_a = 1'b1;
    repeat (6) @(negedge clk);
    #1;
    check("pre_reset_busy", 32'(busy), 32'd1);
    ack0 = ack_cnt;
    rst = 1'b0;
    #1;
    check("mid_reset_outputs", 32'({ack_a, ack_b, err, busy, dcm_update, cur_mode, dcm_prog_in}), 32'd0);
    req_a = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (25) @(negedge clk);
    #1;
    check("no_ack_after_reset", 32'(ack_cnt - ack0), 32'd0);
    check("idle_after_reset", 32'(busy), 32'd0);
    run_vec('{1'b0, 3'd7, 1'b1, 18, 1'b0, 3'd7, 1, 19}, "post_reset");

    // req dropped and mode changed while waiting for the echo
    ack0 = ack_cnt;
    mode_a = 3'd2; req_a = 1'b1;
    e.id = 1'b0; e.err = 1'b0; e.mode = 3'd2; e.cyc = cyc + 19;
    sb.push_back(e);
    repeat (2) @(negedge clk);
    #1;
    req_a = 1'b0; mode_a = 3'd4;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk); #1;
      if (ack_cnt != ack0) seen = 1'b1;
    end
    check("drop_ack_seen", 32'(seen), 32'd1);
    repeat (25) @(negedge clk);
    #1;
    check("drop_single_ack", 32'(ack_cnt - ack0), 32'd1);
    check("drop_idle", 32'(busy), 32'd0);
    check("drop_cur_mode", 32'(cur_mode), 32'd2);

    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
